// File: rtl/scalar_pkg.sv
// Shared scalar-pipeline constants and the writeback request record.
package scalar_pkg;

    localparam int unsigned DATA_WIDTH   = 48;
    localparam int unsigned REGNUM       = 16;
    localparam int unsigned ADDRESSWIDTH = 4;

    typedef struct packed {
        logic [ADDRESSWIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]   data;
    } wb_req_t;

    function automatic logic [REGNUM-1:0] reg_onehot(input logic [ADDRESSWIDTH-1:0] a);
        logic [REGNUM-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/scalar_wb_fifo.sv
// Load-result FIFO for the scalar writeback stage. Exposes per-slot valid/addr so the
// arbiter can see every queued destination register.
module scalar_wb_fifo
    import scalar_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  wb_req_t                              push_req,
    input  logic                                 pop,
    output wb_req_t                              head,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][ADDRESSWIDTH-1:0]   entry_addr
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          push_en, pop_en;
    logic [PW-1:0] off;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: slot contents are only observed through entry_valid.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_req;
    end

    always_comb begin
        off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, off} < count_q);
            entry_addr[i]  = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: merges ALU and buffered load results onto the register-file
// write port, keeping write-after-write order and publishing a pending-write mask.
module scalar_wb_arbiter
    import scalar_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDRESSWIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDRESSWIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    we3,
    output logic [ADDRESSWIDTH-1:0] wa3,
    output logic [DATA_WIDTH-1:0]   wd3,
    output logic [REGNUM-1:0]       pending
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] Limit = SW'(STARVE_LIMIT);

    wb_req_t                            head;
    logic                               full, empty;
    logic [DEPTH-1:0]                   entry_valid;
    logic [DEPTH-1:0][ADDRESSWIDTH-1:0] entry_addr;

    logic                    conflict, force_pop, alu_fire, mem_fire, pop;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    we3_q, we3_d;
    logic [ADDRESSWIDTH-1:0] wa3_q, wa3_d;
    logic [DATA_WIDTH-1:0]   wd3_q, wd3_d;

    scalar_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (mem_fire),
        .push_req    ('{addr: mem_addr, data: mem_data}),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // An ALU write to a register with an older queued load must wait behind it.
    always_comb begin
        conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == alu_addr)) conflict = 1'b1;
        end
    end

    assign force_pop = (starve_q == Limit) & ~empty;
    assign alu_ready = ~conflict & ~force_pop;
    assign alu_fire  = alu_valid & alu_ready;
    assign mem_ready = ~full;
    assign mem_fire  = mem_valid & mem_ready;
    assign pop       = ~empty & ~alu_fire;

    always_comb begin
        starve_d = starve_q;
        we3_d    = alu_fire | pop;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (alu_fire && (starve_q != Limit)) begin
            starve_d = starve_q + SW'(1);
        end
        if (alu_fire) begin
            wa3_d = alu_addr;
            wd3_d = alu_data;
        end else if (pop) begin
            wa3_d = head.addr;
            wd3_d = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            starve_q <= starve_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

    always_comb begin
        pending = we3_q ? reg_onehot(wa3_q) : '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pending = pending | reg_onehot(entry_addr[i]);
        end
    end

endmodule
